// File: rtl/cpu_run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl_pkg
// Shared definitions for the CPU run controller.
//   run_state_e    : controller state encoding (idle, core reset, run, done)
//   trace_entry_w  : width of one trace entry, {timestamp, value}
// -----------------------------------------------------------------------------
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReset = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } run_state_e;

    // A trace entry is the RUN-cycle timestamp concatenated with the core value.
    function automatic int unsigned trace_entry_w(input int unsigned cnt_w,
                                                  input int unsigned data_w);
        return cnt_w + data_w;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Synchronous FIFO holding trace entries, with a registered read port.
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset
//   clr_i      : synchronous clear of both pointers (contents are don't-care)
//   push_i     : write wr_data_i (accepted when not full, or when full and a
//                pop happens in the same cycle)
//   wr_data_i  : entry to write
//   pop_i      : read one entry; ignored while empty
//   rd_data_o  : popped entry, valid the cycle after the pop, otherwise held
//   full_o     : DEPTH entries stored
//   empty_o    : no entries stored
//   dropped_o  : a push this cycle is being discarded because the FIFO is full
// -----------------------------------------------------------------------------
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             dropped_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    always_comb begin
        empty_o   = (wr_ptr_q == rd_ptr_q);
        full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop    = pop_i && !empty_o && !clr_i;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        do_push   = push_i && !clr_i && (!full_o || do_pop);
        dropped_o = push_i && !clr_i && full_o && !do_pop;
        rd_data_o = rd_data_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

    // Storage needs no reset; only slots below the write pointer are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
// Run controller for the CPU core: pulses the core reset, runs the core for a
// programmable number of cycles, then freezes it, tracing every change of the
// core output value with its RUN-cycle timestamp.
//   clk, reset      : clock, asynchronous active-high reset
//   start           : begin a run (taken in IDLE or DONE)
//   stop            : end the current run after this cycle (RUN only)
//   run_cycles      : RUN length, sampled with start
//   inr_in/cpu_inr  : core input value, registered through to the core
//   cpu_reset       : core reset, low only while running
//   cpu_outvalue    : core output value being traced
//   busy, done      : run in progress / run finished
//   cycle_count     : RUN cycles elapsed (saturating)
//   trace_*         : trace FIFO read port, status and sticky overflow
// -----------------------------------------------------------------------------
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned INR_W       = 4,
    parameter int unsigned CNT_W       = 21,
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned TRACE_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic [CNT_W-1:0]        run_cycles,
    input  logic [INR_W-1:0]        inr_in,
    output logic                    cpu_reset,
    output logic [INR_W-1:0]        cpu_inr,
    input  logic [DATA_W-1:0]       cpu_outvalue,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        cycle_count,
    input  logic                    trace_rd_en,
    output logic [CNT_W+DATA_W-1:0] trace_rd_data,
    output logic                    trace_empty,
    output logic                    trace_full,
    output logic                    trace_overflow
);

    localparam int unsigned TW = trace_entry_w(CNT_W, DATA_W);
    localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_e         state_q;
    logic [CNT_W-1:0]   run_len_q;
    logic [RW-1:0]      rst_cnt_q;
    logic [CNT_W-1:0]   cycle_count_q;
    logic [DATA_W-1:0]  prev_q;
    logic               overflow_q;
    logic               cpu_reset_q;
    logic               busy_q;
    logic               done_q;
    logic [INR_W-1:0]   cpu_inr_q;

    logic               launch;
    logic               changed;
    logic               trace_push;
    logic               trace_dropped;
    logic [TW-1:0]      trace_wr_data;

    always_comb begin
        launch        = start && ((state_q == StIdle) || (state_q == StDone));
        changed       = (cpu_outvalue != prev_q);
        trace_push    = (state_q == StRun) && changed;
        trace_wr_data = {cycle_count_q, cpu_outvalue};
    end

    trace_fifo #(
        .WIDTH (TW),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk_i     (clk),
        .rst_i     (reset),
        .clr_i     (launch),
        .push_i    (trace_push),
        .wr_data_i (trace_wr_data),
        .pop_i     (trace_rd_en),
        .rd_data_o (trace_rd_data),
        .full_o    (trace_full),
        .empty_o   (trace_empty),
        .dropped_o (trace_dropped)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            run_len_q     <= '0;
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
            prev_q        <= '0;
            overflow_q    <= 1'b0;
            cpu_reset_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cpu_inr_q     <= '0;
        end else begin
            cpu_inr_q <= inr_in;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q       <= StReset;
                        run_len_q     <= run_cycles;
                        rst_cnt_q     <= RW'(RST_CYCLES - 1);
                        cycle_count_q <= '0;
                        overflow_q    <= 1'b0;
                        cpu_reset_q   <= 1'b1;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                    end
                end
                StReset: begin
                    // Track the core's post-reset value so the first RUN cycle
                    // only logs a genuine change.
                    prev_q <= cpu_outvalue;
                    if (rst_cnt_q == '0) begin
                        if (run_len_q != '0) begin
                            state_q     <= StRun;
                            cpu_reset_q <= 1'b0;
                        end else begin
                            state_q     <= StDone;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end else begin
                        rst_cnt_q <= rst_cnt_q - 1'b1;
                    end
                end
                StRun: begin
                    if (changed) begin
                        prev_q <= cpu_outvalue;
                    end
                    if (trace_dropped) begin
                        overflow_q <= 1'b1;
                    end
                    if (cycle_count_q != '1) begin
                        cycle_count_q <= cycle_count_q + 1'b1;
                    end
                    if (stop || (cycle_count_q == run_len_q - CNT_W'(1))) begin
                        state_q     <= StDone;
                        cpu_reset_q <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        cpu_reset      = cpu_reset_q;
        cpu_inr        = cpu_inr_q;
        busy           = busy_q;
        done           = done_q;
        cycle_count    = cycle_count_q;
        trace_overflow = overflow_q;
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Self-checking bench for cpu_run_ctrl. A behavioural model tracks the run phase,
// cycle count, a queue of trace entries and the overflow flag, advanced once per
// clock from the inputs driven for that cycle.
// -----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

    localparam int DW = 16;
    localparam int IW = 4;
    localparam int CW = 21;
    localparam int RC = 2;
    localparam int TD = 4;
    localparam int TW = CW + DW;
    localparam int VW = CW + IW + TW + 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic [CW-1:0] run_cycles;
    logic [IW-1:0] inr_in;
    logic          cpu_reset;
    logic [IW-1:0] cpu_inr;
    logic [DW-1:0] cpu_outvalue;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycle_count;
    logic          trace_rd_en;
    logic [TW-1:0] trace_rd_data;
    logic          trace_empty;
    logic          trace_full;
    logic          trace_overflow;

    cpu_run_ctrl #(
        .DATA_W      (DW),
        .INR_W       (IW),
        .CNT_W       (CW),
        .RST_CYCLES  (RC),
        .TRACE_DEPTH (TD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .run_cycles     (run_cycles),
        .inr_in         (inr_in),
        .cpu_reset      (cpu_reset),
        .cpu_inr        (cpu_inr),
        .cpu_outvalue   (cpu_outvalue),
        .busy           (busy),
        .done           (done),
        .cycle_count    (cycle_count),
        .trace_rd_en    (trace_rd_en),
        .trace_rd_data  (trace_rd_data),
        .trace_empty    (trace_empty),
        .trace_full     (trace_full),
        .trace_overflow (trace_overflow)
    );

    always #5 clk = ~clk;

    // Model phases: 0 idle, 1 core held in reset, 2 running, 3 finished.
    int            m_ph;
    int            m_rst_left;
    logic [CW-1:0] m_n;
    logic [CW-1:0] m_cnt;
    logic [DW-1:0] m_prev;
    logic [TW-1:0] m_q[$];
    logic [TW-1:0] m_rd;
    bit            m_ovf;
    logic [IW-1:0] m_inr;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [VW-1:0] exp_vec();
        return {(m_ph != 2), (m_ph == 1 || m_ph == 2), (m_ph == 3), m_cnt, m_inr, m_rd,
                (m_q.size() == 0), (m_q.size() == TD), m_ovf};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {cpu_reset, busy, done, cycle_count, cpu_inr, trace_rd_data,
                trace_empty, trace_full, trace_overflow};
    endfunction

    task automatic model_reset();
        m_ph   = 0;
        m_cnt  = '0;
        m_n    = '0;
        m_prev = '0;
        m_q.delete();
        m_rd   = '0;
        m_ovf  = 1'b0;
        m_inr  = '0;
    endtask

    // Apply one clock edge to both model and DUT, leaving time 1 past the edge.
    task automatic tick();
        bit            pop_ok;
        bit            push;
        logic [TW-1:0] ent;
        inr_in = IW'($urandom);
        pop_ok = trace_rd_en && (m_q.size() != 0);
        push   = 1'b0;
        ent    = '0;
        case (m_ph)
            0, 3: begin
                if (start) begin
                    m_ph       = 1;
                    m_rst_left = RC;
                    m_n        = run_cycles;
                    m_cnt      = '0;
                    m_ovf      = 1'b0;
                    m_q.delete();
                    pop_ok     = 1'b0;
                end
            end
            1: begin
                m_prev     = cpu_outvalue;
                m_rst_left = m_rst_left - 1;
                if (m_rst_left == 0) m_ph = (m_n != 0) ? 2 : 3;
            end
            2: begin
                if (cpu_outvalue != m_prev) begin
                    push   = 1'b1;
                    ent    = {m_cnt, cpu_outvalue};
                    m_prev = cpu_outvalue;
                end
                if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
                if (stop || m_cnt == m_n) m_ph = 3;
            end
            default: ;
        endcase
        if (pop_ok) m_rd = m_q.pop_front();
        if (push) begin
            if (m_q.size() < TD) m_q.push_back(ent);
            else m_ovf = 1'b1;
        end
        m_inr = inr_in;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (cpu_reset !== 1'b1) $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (trace_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", trace_empty); else n_pass++;
        n_checks++; if (cycle_count !== '0) $display("FAIL reset_count: got %0d want 0", cycle_count); else n_pass++;
        n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL reset_all: got %h want %h", obs_vec(), exp_vec()); else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL idle_%0d: got %h want %h", i, obs_vec(), exp_vec()); else n_pass++;
        end
    endtask

    task automatic test_normal();
        logic [TW-1:0] want;
        cpu_outvalue = '0;
        run_cycles   = CW'(10);
        start        = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL normal_e0: got %h want %h", obs_vec(), exp_vec()); else n_pass++;
        for (int e = 1; e <= 13; e++) begin
            if (m_ph == 2 && m_cnt == 3) cpu_outvalue = DW'(5);
            if (m_ph == 2 && m_cnt == 7) cpu_outvalue = DW'(9);
            tick();
            n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL normal_e%0d: got %h want %h", e, obs_vec(), exp_vec()); else n_pass++;
            n_checks++; if (cpu_reset !== !(e >= 2 && e <= 11)) $display("FAIL normal_cpu_reset_e%0d: got %b want %b", e, cpu_reset, !(e >= 2 && e <= 11)); else n_pass++;
            n_checks++; if (done !== (e >= 12)) $display("FAIL normal_done_e%0d: got %b want %b", e, done, (e >= 12)); else n_pass++;
        end
        n_checks++; if (cycle_count !== CW'(10)) $display("FAIL normal_count: got %0d want 10", cycle_count); else n_pass++;
        trace_rd_en = 1'b1;
        tick();
        want = {CW'(3), DW'(5)};
        n_checks++; if (trace_rd_data !== want) $display("FAIL normal_rd0: got %h want %h", trace_rd_data, want); else n_pass++;
        tick();
        want = {CW'(7), DW'(9)};
        n_checks++; if (trace_rd_data !== want) $display("FAIL normal_rd1: got %h want %h", trace_rd_data, want); else n_pass++;
        trace_rd_en = 1'b0;
        n_checks++; if (trace_empty !== 1'b1) $display("FAIL normal_empty: got %b want 1", trace_empty); else n_pass++;
        n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL normal_end: got %h want %h", obs_vec(), exp_vec()); else n_pass++;
    endtask

    task automatic test_early_stop();
        bit hit = 1'b0;
        run_cycles = CW'(100);
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 30 && !hit; e++) begin
            stop = (m_ph == 2 && m_cnt == 4);
            tick();
            n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL stop_e%0d: got %h want %h", e, obs_vec(), exp_vec()); else n_pass++;
            if (stop) begin
                hit = 1'b1;
                n_checks++; if (done !== 1'b1) $display("FAIL stop_done: got %b want 1", done); else n_pass++;
                n_checks++; if (cycle_count !== CW'(5)) $display("FAIL stop_count: got %0d want 5", cycle_count); else n_pass++;
                n_checks++; if (cpu_reset !== 1'b1) $display("FAIL stop_cpu_reset: got %b want 1", cpu_reset); else n_pass++;
            end
        end
        n_checks++; if (!hit) $display("FAIL stop_timeout: run cycle 4 never reached (got none, want 1)"); else n_pass++;
        // stop while finished must change nothing
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL stop_in_done: got %h want %h", obs_vec(), exp_vec()); else n_pass++;
    endtask

    task automatic test_overflow_and_zero();
        run_cycles = CW'(8);
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 20 && m_ph != 3; e++) begin
            if (m_ph == 2) cpu_outvalue = cpu_outvalue + 1'b1;
            tick();
            n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL ovf_e%0d: got %h want %h", e, obs_vec(), exp_vec()); else n_pass++;
        end
        n_checks++; if (trace_full !== 1'b1) $display("FAIL ovf_full: got %b want 1", trace_full); else n_pass++;
        n_checks++; if (trace_overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", trace_overflow); else n_pass++;
        trace_rd_en = 1'b1;
        for (int i = 0; i < TD; i++) begin
            tick();
            n_checks++; if (trace_rd_data[TW-1:DW] !== CW'(i)) $display("FAIL ovf_ts%0d: got %0d want %0d", i, trace_rd_data[TW-1:DW], i); else n_pass++;
            n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL ovf_rd%0d: got %h want %h", i, obs_vec(), exp_vec()); else n_pass++;
        end
        trace_rd_en = 1'b0;
        // Refill so the following start has something to clear.
        run_cycles = CW'(6);
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 20 && m_ph != 3; e++) begin
            if (m_ph == 2) cpu_outvalue = cpu_outvalue + 1'b1;
            tick();
        end
        run_cycles = '0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (trace_overflow !== 1'b0) $display("FAIL zero_ovf_clr: got %b want 0", trace_overflow); else n_pass++;
        n_checks++; if (trace_empty !== 1'b1) $display("FAIL zero_empty: got %b want 1", trace_empty); else n_pass++;
        for (int e = 1; e <= 3; e++) begin
            cpu_outvalue = DW'($urandom);
            tick();
            n_checks++; if (cpu_reset !== 1'b1) $display("FAIL zero_cpu_reset_e%0d: got %b want 1", e, cpu_reset); else n_pass++;
            n_checks++; if (done !== (e >= 2)) $display("FAIL zero_done_e%0d: got %b want %b", e, done, (e >= 2)); else n_pass++;
            n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL zero_e%0d: got %h want %h", e, obs_vec(), exp_vec()); else n_pass++;
        end
    endtask

    task automatic test_full_push_pop();
        logic [TW-1:0] want;
        bit            hit = 1'b0;
        cpu_outvalue = 16'hAAAA;
        run_cycles   = CW'(6);
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 20 && m_ph != 3; e++) begin
            if (m_ph == 2) cpu_outvalue = DW'(((m_cnt < 4) ? m_cnt : CW'(4)) + 1);
            trace_rd_en = (m_ph == 2 && m_cnt == 4);
            tick();
            n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL fpp_e%0d: got %h want %h", e, obs_vec(), exp_vec()); else n_pass++;
            if (trace_rd_en) begin
                hit  = 1'b1;
                want = {CW'(0), DW'(1)};
                n_checks++; if (trace_full !== 1'b1) $display("FAIL fpp_full: got %b want 1", trace_full); else n_pass++;
                n_checks++; if (trace_overflow !== 1'b0) $display("FAIL fpp_ovf: got %b want 0", trace_overflow); else n_pass++;
                n_checks++; if (trace_rd_data !== want) $display("FAIL fpp_rd: got %h want %h", trace_rd_data, want); else n_pass++;
            end
        end
        trace_rd_en = 1'b0;
        n_checks++; if (!hit) $display("FAIL fpp_timeout: pop cycle never reached (got none, want 1)"); else n_pass++;
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 8; r++) begin
            int  stop_at = $urandom_range(0, 25);
            int  chg     = $urandom_range(10, 90);
            int  rd      = $urandom_range(0, 60);
            int  tail    = 0;
            trace_rd_en = 1'b0;
            run_cycles  = CW'($urandom_range(0, 20));
            start       = 1'b1;
            tick();
            start = 1'b0;
            n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL rand%0d_start: got %h want %h", r, obs_vec(), exp_vec()); else n_pass++;
            for (int e = 0; e < 60 && tail < 6; e++) begin
                stop = (m_ph == 2 && m_cnt == CW'(stop_at));
                if ($urandom_range(0, 99) < chg) cpu_outvalue = DW'($urandom_range(0, 3));
                trace_rd_en = ($urandom_range(0, 99) < rd);
                tick();
                n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL rand%0d_e%0d: got %h want %h", r, e, obs_vec(), exp_vec()); else n_pass++;
                if (m_ph == 3) tail++;
            end
            stop        = 1'b0;
            trace_rd_en = 1'b0;
            n_checks++; if (tail < 6) $display("FAIL rand%0d_timeout: run not finished (got busy, want done)", r); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        bit hit = 1'b0;
        run_cycles = CW'(50);
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 30 && !hit; e++) begin
            if (m_ph == 2) cpu_outvalue = DW'($urandom);
            tick();
            n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL arst_e%0d: got %h want %h", e, obs_vec(), exp_vec()); else n_pass++;
            if (m_ph == 2 && m_cnt == 6) begin
                hit = 1'b1;
                #2 reset = 1'b1;
                #1;
                n_checks++; if (cpu_reset !== 1'b1) $display("FAIL arst_cpu_reset: got %b want 1", cpu_reset); else n_pass++;
                n_checks++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy); else n_pass++;
                n_checks++; if (cycle_count !== '0) $display("FAIL arst_count: got %0d want 0", cycle_count); else n_pass++;
                n_checks++; if (trace_empty !== 1'b1) $display("FAIL arst_empty: got %b want 1", trace_empty); else n_pass++;
            end
        end
        n_checks++; if (!hit) $display("FAIL arst_timeout: run cycle 6 never reached (got none, want 1)"); else n_pass++;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL arst_held: got %h want %h", obs_vec(), exp_vec()); else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL arst_idle: got %h want %h", obs_vec(), exp_vec()); else n_pass++;
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        run_cycles   = '0;
        inr_in       = '0;
        cpu_outvalue = '0;
        trace_rd_en  = 1'b0;
        test_reset();
        test_normal();
        test_early_stop();
        test_overflow_and_zero();
        test_full_push_pop();
        test_random_runs();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached with %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
